reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: four requesters compete for a small register bank.
// A two-state FSM (IDLE/WRITE) grants one requester per arbitration.
// It latches that requester's address and data, then commits the write on the next edge.
// Arbitration is round-robin from a rotating pointer.
// Optional feature macro: REG_WRITE_ARB_PRIO_EN.
// When it is defined, requester 0 has absolute priority.
// Requesters 1-3 then rotate among themselves.
module reg_write_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [4*AW-1:0] wr_addr,
    input  logic [4*DW-1:0] wr_data,
    output logic [3:0]      gnt,
    output logic            busy,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    localparam int NREG = 2**AW;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      win_q, win_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            bank_we;
    logic [DW-1:0]   bank_q [NREG];

    logic            found;
    logic [1:0]      win_sel;

    // Pick the first requesting index, searching upward from ptr and wrapping 3->0.
    always_comb begin
        logic [1:0] idx;
        found   = 1'b0;
        win_sel = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
`ifdef REG_WRITE_ARB_PRIO_EN
            // Requester 0 is handled separately below, so the rotation skips it.
            if (!found && idx != 2'd0 && req[idx]) begin
`else
            if (!found && req[idx]) begin
`endif
                found   = 1'b1;
                win_sel = idx;
            end
        end
`ifdef REG_WRITE_ARB_PRIO_EN
        if (req[0]) begin
            found   = 1'b1;
            win_sel = 2'd0;
        end
`endif
    end

    // Next state: IDLE latches a winner, and WRITE commits it and always returns to IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        bank_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = win_sel;
                    addr_d  = wr_addr[win_sel*AW +: AW];
                    data_d  = wr_data[win_sel*DW +: DW];
                    gnt_d   = 4'b0001 << win_sel;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The held values are committed regardless of what req is doing now.
                bank_we = 1'b1;
                state_d = IDLE;
`ifdef REG_WRITE_ARB_PRIO_EN
                // A requester-0 grant must not disturb the rotation among 1-3.
                if (win_q != 2'd0) begin
                    ptr_d = win_q + 2'd1;
                end
`else
                ptr_d = win_q + 2'd1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and holding registers; reset clears everything and aborts any pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            win_q   <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    // One register per bank entry, written only in the WRITE state at the held address.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bank
        always_ff @(posedge clk) begin
            if (!reset) begin
                bank_q[gi] <= '0;
            end else if (bank_we && addr_q == AW'(gi)) begin
                bank_q[gi] <= data_q;
            end
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter.
// A transaction-level model holds the bank contents and the round-robin pointer.
// Directed steps come first, followed by randomized transactions.
module tb_reg_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [4*AW-1:0] wr_addr = '0;
    logic [4*DW-1:0] wr_data = '0;
    logic [3:0]      gnt;
    logic            busy;
    logic [AW-1:0]   rd_addr = '0;
    logic [DW-1:0]   rd_data;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_bank [4];
    int            m_ptr;

    reg_write_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Winner according to the arbitration rules, or -1 if nobody is requesting.
    function automatic int m_winner(input logic [3:0] r);
`ifdef REG_WRITE_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
`ifdef REG_WRITE_ARB_PRIO_EN
            if (i == 0) continue;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset;
        reset = 1'b0;
        req   = 4'b1111;
        step;
        step;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            #1;
            chk("rst_rd", 32'(rd_data), 32'd0);
        end
        for (int a = 0; a < 4; a++) m_bank[a] = '0;
        m_ptr = 0;
        reset = 1'b1;
        req   = 4'b0000;
    endtask

    // Perform one arbitration from IDLE.
    // If there is a winner, also run the following WRITE cycle.
    task automatic txn(input logic [3:0] r, input logic [4*AW-1:0] a, input logic [4*DW-1:0] d,
                       input logic [AW-1:0] ra, input bit rnd, output logic [3:0] g);
        int w;
        logic [AW-1:0] wa;
        req     = r;
        wr_addr = a;
        wr_data = d;
        rd_addr = ra;
        w = m_winner(r);
        step;
        g = gnt;
        chk("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("busy", 32'(busy), (w < 0) ? 32'd0 : 32'd1);
        chk("rd_old", 32'(rd_data), 32'(m_bank[ra]));
        if (w >= 0) begin
            wa = a[w*AW +: AW];
            m_bank[wa] = d[w*DW +: DW];
`ifdef REG_WRITE_ARB_PRIO_EN
            if (w != 0) m_ptr = (w + 1) % 4;
`else
            m_ptr = (w + 1) % 4;
`endif
            if (rnd) begin
                req     = 4'($urandom);
                wr_addr = (4*AW)'($urandom);
                wr_data = (4*DW)'($urandom);
            end
            step;
            chk("gnt_drop", 32'(gnt), 32'd0);
            chk("busy_drop", 32'(busy), 32'd0);
            chk("rd_new", 32'(rd_data), 32'(m_bank[ra]));
        end
    endtask

    initial begin
        logic [3:0] g;

        // Reset with every requester asserting.
        do_reset();

        // Single write: requester 2 writes A5 to address 3.
        txn(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, {8'h00, 8'hA5, 8'h00, 8'h00}, 2'd3, 1'b0, g);
        chk("single_gnt", 32'(g), 32'b0100);
        chk("single_bank3", 32'(rd_data), 32'hA5);
        req = 4'b0000;
        step;
        chk("single_idle_gnt", 32'(gnt), 32'd0);

`ifndef REG_WRITE_ARB_PRIO_EN
        // Round-robin with all requesters held high.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            txn(4'b1111, 8'hE4, 32'h44332211, 2'd0, 1'b0, g);
            chk("rr_seq", 32'(g), 32'd1 << (k % 4));
        end
`else
        // Requester 0 wins every arbitration while it requests.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            txn(4'b1011, 8'hE4, 32'h44332211, 2'd0, 1'b0, g);
            chk("prio_r0", 32'(g), 32'b0001);
        end
        for (int k = 0; k < 4; k++) begin
            txn(4'b1010, 8'hE4, 32'h44332211, 2'd1, 1'b0, g);
            chk("prio_alt", 32'(g), (k % 2 == 0) ? 32'b0010 : 32'b1000);
        end
`endif

        // Abort: reset lands on the busy cycle of a 3C write to address 1.
        do_reset();
        req     = 4'b0010;
        wr_addr = {2'd0, 2'd0, 2'd1, 2'd0};
        wr_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        rd_addr = 2'd1;
        step;
        chk("abort_gnt", 32'(gnt), 32'b0010);
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step;
        chk("abort_gnt_clr", 32'(gnt), 32'd0);
        chk("abort_busy_clr", 32'(busy), 32'd0);
        chk("abort_bank1", 32'(rd_data), 32'd0);
        reset = 1'b1;
        req   = 4'b0000;
        step;
        chk("abort_no_pulse", 32'(gnt), 32'd0);
        chk("abort_bank1_after", 32'(rd_data), 32'd0);
        for (int a = 0; a < 4; a++) m_bank[a] = '0;
        m_ptr = 0;

        // Read-during-write on address 2.
        do_reset();
        txn(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, {8'h00, 8'h00, 8'h00, 8'h11}, 2'd2, 1'b0, g);
        req     = 4'b0010;
        wr_addr = {2'd0, 2'd0, 2'd2, 2'd0};
        wr_data = {8'h00, 8'h00, 8'h22, 8'h00};
        step;
        chk("rdw_gnt", 32'(gnt), 32'b0010);
        chk("rdw_old", 32'(rd_data), 32'h11);
        req = 4'b0000;
        step;
        chk("rdw_new", 32'(rd_data), 32'h22);
        m_bank[2] = 8'h22;
        m_ptr     = 2;

        // Randomized transactions against the model.
        for (int n = 0; n < 200; n++) begin
            txn(4'($urandom_range(0, 15)), (4*AW)'($urandom), (4*DW)'($urandom),
                AW'($urandom), 1'b1, g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
